// File: rtl/mem_access_stage.sv
// MEM stage: classifies EX/MEM ops, runs one data-memory access with timeout, extends load data.
// Latency: non-mem ops 0 cycles; memory ops stall upstream from issue until ack (+1 DONE cycle).
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        regwrite_in,
    input  logic        memread_in,
    input  logic        memwrite_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] ALU_data_in,
    input  logic [31:0] store_data_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        regwrite_MEM,
    output logic        memread_MEM,
    output logic [4:0]  rd_MEM,
    output logic [31:0] ALU_data_MEM,
    output logic [31:0] mem_data_MEM,
    output logic        stall_MEM,
    output logic        access_exc,
    output logic        bus_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_mem_data;
    logic [3:0]    r_be;
    logic          r_we;
    logic [1:0]    r_off;
    logic [2:0]    r_f3;

    logic w_memop, w_f3_ok, w_illegal, w_misalign;
    logic w_idle, w_wait, w_exc, w_start, w_at_limit, w_timeout, w_stall, w_kill;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_shift, w_load;
    logic [15:0] w_half;

    assign w_memop    = valid_in & (memread_in ^ memwrite_in);
    assign w_f3_ok    = memwrite_in ? (funct3_in inside {3'b000, 3'b001, 3'b010})
                                    : (funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign w_illegal  = (valid_in & memread_in & memwrite_in) | (w_memop & ~w_f3_ok);
    assign w_misalign = w_memop & (((funct3_in[1:0] == 2'b10) & (|ALU_data_in[1:0]))
                                 | ((funct3_in[1:0] == 2'b01) & ALU_data_in[0]));

    assign w_idle     = (r_state == S_IDLE);
    assign w_wait     = (r_state == S_WAIT);
    assign w_exc      = reset & w_idle & (w_illegal | w_misalign);
    assign w_start    = reset & w_idle & w_memop & ~w_illegal & ~w_misalign;
    // The request is withdrawn in the limit cycle; a late ack there still completes the access.
    assign w_at_limit = w_wait & (r_cnt == LIMIT);
    assign w_timeout  = reset & w_at_limit & ~dmem_ack;
    assign w_stall    = reset & (w_start | (w_wait & ~w_timeout));
    assign w_kill     = w_stall | w_exc | w_timeout | ~reset;

    assign dmem_req     = reset & w_wait & ~w_at_limit;
    assign dmem_we      = r_we;
    assign dmem_addr    = r_addr;
    assign dmem_wdata   = r_wdata;
    assign dmem_be      = r_be;
    assign stall_MEM    = w_stall;
    assign access_exc   = w_exc;
    assign bus_err      = w_timeout;
    assign regwrite_MEM = valid_in & regwrite_in & ~w_kill;
    assign memread_MEM  = valid_in & memread_in & ~w_kill;
    assign rd_MEM       = rd_in;
    assign ALU_data_MEM = ALU_data_in;
    assign mem_data_MEM = r_mem_data;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = store_data_in;
        if (memwrite_in) begin
            case (funct3_in[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << ALU_data_in[1:0];
                    w_wdata = {4{store_data_in[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << {ALU_data_in[1], 1'b0};
                    w_wdata = {2{store_data_in[15:0]}};
                end
                default: ;
            endcase
        end
    end

    assign w_shift = dmem_rdata >> {r_off, 3'b000};
    assign w_half  = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        case (r_f3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_we       <= 1'b0;
            r_off      <= '0;
            r_f3       <= '0;
            r_mem_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                        r_addr  <= {ALU_data_in[31:2], 2'b00};
                        r_we    <= memwrite_in;
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_off   <= ALU_data_in[1:0];
                        r_f3    <= funct3_in;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        if (!r_we) r_mem_data <= w_load;
                        r_state <= S_DONE;
                    end else if (w_at_limit) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios then random ops against a byte-lane arithmetic model.
module tb_mem_access_stage;
    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, regwrite_in, memread_in, memwrite_in;
    logic [2:0]  funct3_in;
    logic [4:0]  rd_in;
    logic [31:0] ALU_data_in, store_data_in;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        regwrite_MEM, memread_MEM;
    logic [4:0]  rd_MEM;
    logic [31:0] ALU_data_MEM, mem_data_MEM;
    logic        stall_MEM, access_exc, bus_err;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_mem;

    mem_access_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .regwrite_in(regwrite_in),
        .memread_in(memread_in), .memwrite_in(memwrite_in), .funct3_in(funct3_in),
        .rd_in(rd_in), .ALU_data_in(ALU_data_in), .store_data_in(store_data_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .regwrite_MEM(regwrite_MEM), .memread_MEM(memread_MEM),
        .rd_MEM(rd_MEM), .ALU_data_MEM(ALU_data_MEM), .mem_data_MEM(mem_data_MEM),
        .stall_MEM(stall_MEM), .access_exc(access_exc), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    task automatic probe;
        #4;
    endtask

    function automatic int sz(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit is_illegal(input logic mr, input logic mw, input logic [2:0] f3);
        if (mr && mw) return 1'b1;
        if (mw) return f3 > 3'd2;
        if (mr) return (f3 == 3'd3) || (f3 > 3'd5);
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_be(input logic mw, input logic [2:0] f3, input logic [31:0] a);
        int m;
        if (!mw) return 4'hF;
        m = ((1 << sz(f3)) - 1) << a[1:0];
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (sz(f3) == 1) return {24'd0, sd[7:0]} * 32'h0101_0101;
        if (sz(f3) == 2) return {16'd0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        longint v, one;
        int bits;
        one  = 1;
        bits = 8 * sz(f3);
        v    = longint'(rd) >> (8 * int'(a[1:0]));
        if (bits < 32) begin
            v = v & ((one << bits) - 1);
            if (!f3[2] && v >= (one << (bits - 1))) v = v - (one << bits);
        end
        return v[31:0];
    endfunction

    // One upstream instruction, held until the stage releases it; delay > T means no ack ever.
    task automatic run_op(input logic v, input logic rw, input logic mr, input logic mw,
                          input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rdata, input int delay,
                          input logic stray, input string tag);
        bit memop, bad, ack;
        valid_in = v; regwrite_in = rw; memread_in = mr; memwrite_in = mw;
        funct3_in = f3; rd_in = rd; ALU_data_in = a; store_data_in = sd;
        dmem_ack = stray; dmem_rdata = $urandom;
        memop = v && (mr ^ mw);
        bad   = v && (is_illegal(mr, mw, f3) || (memop && (int'(a[2:0]) % sz(f3) != 0)));
        probe;
        chk({tag, ".rd"}, 32'(rd_MEM), 32'(rd));
        chk({tag, ".alu"}, ALU_data_MEM, a);
        chk({tag, ".memdata_hold"}, mem_data_MEM, exp_mem);
        chk({tag, ".req_idle"}, 32'(dmem_req), 32'd0);
        chk({tag, ".exc"}, 32'(access_exc), 32'(bad));
        if (bad || !memop) begin
            chk({tag, ".stall"}, 32'(stall_MEM), 32'd0);
            chk({tag, ".regwrite"}, 32'(regwrite_MEM), 32'(v && rw && !bad));
            chk({tag, ".memread"}, 32'(memread_MEM), 32'(v && mr && !bad));
            adv;
            return;
        end
        chk({tag, ".stall_issue"}, 32'(stall_MEM), 32'd1);
        chk({tag, ".regwrite_issue"}, 32'(regwrite_MEM), 32'd0);
        adv;
        for (int w = 0; w <= T; w++) begin
            ack = (w == delay);
            dmem_ack = ack;
            dmem_rdata = ack ? rdata : $urandom;
            probe;
            chk({tag, ".req"}, 32'(dmem_req), 32'(w < T));
            chk({tag, ".addr"}, dmem_addr, {a[31:2], 2'b00});
            chk({tag, ".we"}, 32'(dmem_we), 32'(mw));
            chk({tag, ".be"}, 32'(dmem_be), 32'(exp_be(mw, f3, a)));
            if (mw) chk({tag, ".wdata"}, dmem_wdata, exp_wdata(f3, sd));
            chk({tag, ".stall_wait"}, 32'(stall_MEM), 32'((w < T) || ack));
            chk({tag, ".bus_err"}, 32'(bus_err), 32'((w == T) && !ack));
            chk({tag, ".regwrite_wait"}, 32'(regwrite_MEM), 32'd0);
            adv;
            dmem_ack = 1'b0;
            if (ack) break;
            if (w == T) return;
        end
        if (mr) exp_mem = exp_load(f3, a, rdata);
        probe;
        chk({tag, ".stall_done"}, 32'(stall_MEM), 32'd0);
        chk({tag, ".req_done"}, 32'(dmem_req), 32'd0);
        chk({tag, ".regwrite_done"}, 32'(regwrite_MEM), 32'(rw));
        chk({tag, ".memread_done"}, 32'(memread_MEM), 32'(mr));
        chk({tag, ".memdata"}, mem_data_MEM, exp_mem);
        adv;
    endtask

    initial begin
        logic [2:0] f3;
        logic mr, mw;
        int kind;
        reset = 1'b0; valid_in = 1'b1; regwrite_in = 1'b1; memread_in = 1'b0; memwrite_in = 1'b0;
        funct3_in = 3'd0; rd_in = 5'd1; ALU_data_in = 32'h10; store_data_in = 32'd0;
        dmem_rdata = 32'd0; dmem_ack = 1'b0;
        exp_mem = 32'd0;
        adv; adv;
        probe;
        chk("rst.stall", 32'(stall_MEM), 32'd0);
        chk("rst.regwrite", 32'(regwrite_MEM), 32'd0);
        chk("rst.req", 32'(dmem_req), 32'd0);
        chk("rst.be", 32'(dmem_be), 32'd0);
        chk("rst.addr", dmem_addr, 32'd0);
        chk("rst.wdata", dmem_wdata, 32'd0);
        chk("rst.memdata", mem_data_MEM, 32'd0);
        chk("rst.exc", 32'(access_exc), 32'd0);
        chk("rst.bus_err", 32'(bus_err), 32'd0);
        adv;
        reset = 1'b1;

        run_op(1, 1, 0, 0, 3'b000, 5'd5, 32'h1234, 32'd0, 32'd0, 0, 0, "add");
        run_op(1, 1, 1, 0, 3'b000, 5'd7, 32'h103, 32'd0, 32'h80FF_0000, 0, 0, "lb");
        chk("lb.value", mem_data_MEM, 32'hFFFF_FF80);
        run_op(1, 0, 0, 1, 3'b001, 5'd0, 32'h22, 32'hDEAD_BEEF, 32'd0, 2, 0, "sh");
        run_op(1, 1, 1, 0, 3'b010, 5'd3, 32'h41, 32'd0, 32'd0, 0, 0, "lw_mis");
        run_op(1, 1, 1, 0, 3'b010, 5'd4, 32'h80, 32'd0, 32'h1111_2222, 99, 0, "lw_to");
        run_op(1, 1, 1, 0, 3'b101, 5'd6, 32'h46, 32'd0, 32'h9876_5432, T, 0, "lhu_lim");
        chk("lhu_lim.value", mem_data_MEM, 32'h0000_9876);

        // Abandon an access mid-WAIT; an ack arriving afterwards must be ignored.
        valid_in = 1'b1; regwrite_in = 1'b1; memread_in = 1'b1; memwrite_in = 1'b0;
        funct3_in = 3'b010; ALU_data_in = 32'h200; dmem_ack = 1'b0;
        adv;
        probe;
        chk("rstw.req_before", 32'(dmem_req), 32'd1);
        adv;
        reset = 1'b0;
        adv;
        probe;
        chk("rstw.req_after", 32'(dmem_req), 32'd0);
        chk("rstw.stall_after", 32'(stall_MEM), 32'd0);
        adv;
        reset = 1'b1; valid_in = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hAAAA_5555;
        adv;
        dmem_ack = 1'b0;
        exp_mem = 32'd0;
        probe;
        chk("rstw.late_ack_mem", mem_data_MEM, 32'd0);
        chk("rstw.late_ack_req", 32'(dmem_req), 32'd0);
        adv;

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            mr = (kind >= 3 && kind <= 6) || kind == 9;
            mw = (kind >= 7);
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                             : (mw ? 3'($urandom_range(0, 2))
                                                   : 3'(($urandom_range(0, 4) + 1) % 5 == 3 ? 4 : $urandom_range(0, 2)));
            run_op(1'($urandom_range(0, 7) != 0), 1'($urandom), mr, mw, f3, 5'($urandom),
                   $urandom, $urandom, $urandom, $urandom_range(0, T + 1), 1'($urandom), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
